// File: rtl/midi_msg_parser.sv
// midi_msg_parser
// Decodes the MIDI byte stream from the UART receiver into Note On / Note Off
// events and queues them in a small first-word-fall-through FIFO.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   i_data, i_vld   received MIDI byte and its one-cycle valid strobe
//   o_evt_vld       FIFO head holds a valid event
//   i_evt_rdy       consumer accepts the head event
//   o_note_on       1 = Note On, 0 = Note Off (or Note On with velocity 0)
//   o_note          note number of the head event
//   o_velocity      velocity of the head event
//   o_channel       MIDI channel of the head event
//   o_fifo_count    number of queued events
//   o_overflow      sticky: an event was dropped because the FIFO was full
//   i_clr_ovf       clears o_overflow
//
// Handshake: an event transfers on every cycle where o_evt_vld & i_evt_rdy.
// While o_evt_vld is high and i_evt_rdy is low the head fields do not change.
// With the FIFO empty the fields keep showing the last event handed out.
module midi_msg_parser #(
    parameter int C_OMNI       = 1,
    parameter int C_CHANNEL    = 0,
    parameter int C_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        i_data,
    input  logic                              i_vld,
    output logic                              o_evt_vld,
    input  logic                              i_evt_rdy,
    output logic                              o_note_on,
    output logic [6:0]                        o_note,
    output logic [6:0]                        o_velocity,
    output logic [3:0]                        o_channel,
    output logic [$clog2(C_FIFO_DEPTH):0]     o_fifo_count,
    output logic                              o_overflow,
    input  logic                              i_clr_ovf
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 19;  // {note_on, note[6:0], velocity[6:0], channel[3:0]}

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Message decoder
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [3:0]   type_q, type_d;
    logic [3:0]   chan_q, chan_d;
    logic [6:0]   d1_q, d1_d;
    logic         evt_push;
    logic [EW-1:0] evt_data;
    logic         chan_match;
    logic         evt_note_on;

    assign chan_match  = (C_OMNI != 0) || (chan_q == 4'(C_CHANNEL));
    // A Note On with velocity 0 is a Note Off by MIDI convention.
    assign evt_note_on = (type_q == 4'h9) && (i_data[6:0] != 7'd0);
    assign evt_data    = {evt_note_on, d1_q, i_data[6:0], chan_q};

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        chan_d   = chan_q;
        d1_d     = d1_q;
        evt_push = 1'b0;
        // Real-time bytes (0xF8-0xFF) fall outside this test and leave every
        // piece of decoder state untouched, so they can sit between data bytes.
        if (i_vld && (i_data < 8'hF8)) begin
            if (i_data[7:4] == 4'hF) begin
                // System common / SysEx: running status is lost.
                state_d = ST_IDLE;
                type_d  = 4'h0;
                chan_d  = 4'h0;
            end else if (i_data[7]) begin
                type_d  = i_data[7:4];
                chan_d  = i_data[3:0];
                state_d = ST_WAIT_D1;
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        d1_d = i_data[6:0];
                        if ((type_q == 4'hC) || (type_q == 4'hD)) begin
                            state_d = ST_WAIT_D1;
                        end else begin
                            state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        // Back to WAIT_D1 keeps running status alive.
                        state_d = ST_WAIT_D1;
                        if (((type_q == 4'h8) || (type_q == 4'h9)) && chan_match) begin
                            evt_push = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            type_q  <= 4'h0;
            chan_q  <= 4'h0;
            d1_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            chan_q  <= chan_d;
            d1_q    <= d1_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] hold_q, hold_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          pop;
    logic          do_push;
    logic [EW-1:0] head;

    assign full    = (count_q == CW'(C_FIFO_DEPTH));
    assign pop     = o_evt_vld && i_evt_rdy;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = evt_push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end
        if (do_push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - CW'(1);
        end
        // Set has priority over clear so a drop is never lost.
        if (evt_push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: it is only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= evt_data;
        end
    end

    // hold_q is the last popped entry, shown while the FIFO is empty.
    assign head = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;

    assign o_evt_vld    = (count_q != '0);
    assign o_note_on    = head[18];
    assign o_note       = head[17:11];
    assign o_velocity   = head[10:4];
    assign o_channel    = head[3:0];
    assign o_fifo_count = count_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
module tb_midi_msg_parser;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] i_data = 8'h00;
  logic       i_vld = 1'b0;
  logic       i_clr_ovf = 1'b0;

  // omni instance
  logic       i_evt_rdy = 1'b0;
  logic       o_evt_vld, o_note_on, o_overflow;
  logic [6:0] o_note, o_velocity;
  logic [3:0] o_channel;
  logic [2:0] o_fifo_count;

  // channel-2 filtered instance
  logic       f_evt_rdy = 1'b0;
  logic       f_evt_vld, f_note_on, f_overflow;
  logic [6:0] f_note, f_velocity;
  logic [3:0] f_channel;
  logic [2:0] f_fifo_count;

  midi_msg_parser #(.C_OMNI(1), .C_CHANNEL(0), .C_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_vld(i_vld),
    .o_evt_vld(o_evt_vld), .i_evt_rdy(i_evt_rdy), .o_note_on(o_note_on),
    .o_note(o_note), .o_velocity(o_velocity), .o_channel(o_channel),
    .o_fifo_count(o_fifo_count), .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
  );

  midi_msg_parser #(.C_OMNI(0), .C_CHANNEL(2), .C_FIFO_DEPTH(4)) dut_f (
    .clk(clk), .rst(rst), .i_data(i_data), .i_vld(i_vld),
    .o_evt_vld(f_evt_vld), .i_evt_rdy(f_evt_rdy), .o_note_on(f_note_on),
    .o_note(f_note), .o_velocity(f_velocity), .o_channel(f_channel),
    .o_fifo_count(f_fifo_count), .o_overflow(f_overflow), .i_clr_ovf(1'b0)
  );

  // scoreboard: events packed as {note_on, note, velocity, channel}
  logic [18:0] exp_q[$];
  logic [18:0] expf_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [18:0] mk(input logic on, input logic [6:0] note,
                                     input logic [6:0] vel, input logic [3:0] ch);
    return {on, note, vel, ch};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic send(input logic [7:0] b);
    i_data = b;
    i_vld  = 1'b1;
    @(negedge clk);
    i_vld  = 1'b0;
  endtask

  // wait (bounded) for a head event, compare against the scoreboard, pop it
  task automatic expect_evt(input bit filt);
    int waited;
    logic [18:0] e;
    logic [18:0] got;
    logic vld;
    waited = 0;
    vld = filt ? f_evt_vld : o_evt_vld;
    while (!vld && waited < 20) begin
      @(negedge clk);
      waited++;
      vld = filt ? f_evt_vld : o_evt_vld;
    end
    check(filt ? "f_evt_vld" : "evt_vld", {31'd0, vld}, 32'd1);
    check(filt ? "f_exp_q_size" : "exp_q_size",
          filt ? expf_q.size() : exp_q.size(), 32'd1 + (filt ? expf_q.size() - 1 : exp_q.size() - 1));
    if (filt ? (expf_q.size() == 0) : (exp_q.size() == 0)) begin
      check("scoreboard_underflow", 32'd1, {31'd0, vld} + 32'd1);
    end else begin
      e   = filt ? expf_q.pop_front() : exp_q.pop_front();
      got = filt ? {f_note_on, f_note, f_velocity, f_channel}
                 : {o_note_on, o_note, o_velocity, o_channel};
      check(filt ? "f_evt" : "evt", {13'd0, got}, {13'd0, e});
    end
    if (filt) f_evt_rdy = 1'b1; else i_evt_rdy = 1'b1;
    @(negedge clk);
    f_evt_rdy = 1'b0;
    i_evt_rdy = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_vld", {31'd0, o_evt_vld}, 32'd0);
    check("rst_count", {29'd0, o_fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check("rst_fields", {13'd0, o_note_on, o_note, o_velocity, o_channel}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single Note On, latency of o_evt_vld
    send(8'h90);
    send(8'h3C);
    i_data = 8'h64;
    i_vld  = 1'b1;
    check("t1_vld_before", {31'd0, o_evt_vld}, 32'd0);
    @(negedge clk);
    i_vld = 1'b0;
    check("t1_vld_after", {31'd0, o_evt_vld}, 32'd1);
    check("t1_count", {29'd0, o_fifo_count}, 32'd1);
    exp_q.push_back(mk(1'b1, 7'h3C, 7'h64, 4'd0));
    expect_evt(1'b0);

    // running status, velocity-0 Note On becomes Note Off
    send(8'h93); send(8'h40); send(8'h50); send(8'h40); send(8'h00);
    exp_q.push_back(mk(1'b1, 7'h40, 7'h50, 4'd3));
    exp_q.push_back(mk(1'b0, 7'h40, 7'h00, 4'd3));
    check("t2_count", {29'd0, o_fifo_count}, 32'd2);
    expect_evt(1'b0);
    expect_evt(1'b0);

    // real-time byte between data bytes
    send(8'h80); send(8'h3C); send(8'hF8); send(8'h7F);
    exp_q.push_back(mk(1'b0, 7'h3C, 7'h7F, 4'd0));
    expect_evt(1'b0);
    check("t3_hold_note", {25'd0, o_note}, 32'h3C);
    check("t3_hold_vel", {25'd0, o_velocity}, 32'h7F);
    // SysEx drops running status: later data bytes make no event
    send(8'hF0); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    repeat (2) @(negedge clk);
    check("t3_idle_count", {29'd0, o_fifo_count}, 32'd0);
    check("t3_idle_vld", {31'd0, o_evt_vld}, 32'd0);

    // channel filter (dut_f accepts channel 2 only)
    send(8'h91); send(8'h30); send(8'h40);
    send(8'h92); send(8'h30); send(8'h40);
    exp_q.push_back(mk(1'b1, 7'h30, 7'h40, 4'd1));
    exp_q.push_back(mk(1'b1, 7'h30, 7'h40, 4'd2));
    expf_q.push_back(mk(1'b1, 7'h30, 7'h40, 4'd2));
    send(8'hC2); send(8'h05); send(8'h30); send(8'h40);
    repeat (2) @(negedge clk);
    check("t4_f_count", {29'd0, f_fifo_count}, 32'd1);
    check("t4_count", {29'd0, o_fifo_count}, 32'd2);
    expect_evt(1'b1);
    expect_evt(1'b0);
    expect_evt(1'b0);
    check("t4_f_empty", {29'd0, f_fifo_count}, 32'd0);

    // overflow with consumer stalled
    send(8'h90);
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i));
      send(8'h20 + 8'(i));
      exp_q.push_back(mk(1'b1, 7'h10 + 7'(i), 7'h20 + 7'(i), 4'd0));
    end
    check("t5_full_count", {29'd0, o_fifo_count}, 32'd4);
    check("t5_no_ovf_yet", {31'd0, o_overflow}, 32'd0);
    // fifth event dropped while clear is asserted: set wins
    send(8'h14);
    i_data = 8'h24; i_vld = 1'b1; i_clr_ovf = 1'b1;
    @(negedge clk);
    i_vld = 1'b0; i_clr_ovf = 1'b0;
    check("t5_ovf_set", {31'd0, o_overflow}, 32'd1);
    check("t5_count", {29'd0, o_fifo_count}, 32'd4);
    check("t5_head", {13'd0, o_note_on, o_note, o_velocity, o_channel},
          {13'd0, mk(1'b1, 7'h10, 7'h20, 4'd0)});
    i_clr_ovf = 1'b1;
    @(negedge clk);
    i_clr_ovf = 1'b0;
    check("t5_ovf_clr", {31'd0, o_overflow}, 32'd0);
    // push and pop in the same cycle while full
    send(8'h15);
    i_data = 8'h25; i_vld = 1'b1; i_evt_rdy = 1'b1;
    @(negedge clk);
    i_vld = 1'b0; i_evt_rdy = 1'b0;
    check("t5_pushpop_count", {29'd0, o_fifo_count}, 32'd4);
    check("t5_pushpop_ovf", {31'd0, o_overflow}, 32'd0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(1'b1, 7'h15, 7'h25, 4'd0));
    for (int i = 0; i < 4; i++) expect_evt(1'b0);
    check("t5_drained", {29'd0, o_fifo_count}, 32'd0);

    // reset mid-message discards partial message and FIFO contents
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h3C);
    check("t6_pre_count", {29'd0, o_fifo_count}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_count", {29'd0, o_fifo_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h64);
    repeat (2) @(negedge clk);
    check("t6_vld", {31'd0, o_evt_vld}, 32'd0);
    check("t6_count", {29'd0, o_fifo_count}, 32'd0);
    check("t6_fields", {13'd0, o_note_on, o_note, o_velocity, o_channel}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
